lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  MEM-stage load/store initiator that drives the word-only data memory (r_enable/w_enable/address/wr_data in, re_data out).
//  - Sub-word loads: byte lane select plus sign/zero extension.
//  - Sub-word stores: two-cycle read-modify-write (RMW), because the memory writes whole words only.
//  - Also flags misaligned, unsupported and out-of-range accesses.
//  - Pipeline side: a valid/ready request and a one-cycle resp_valid pulse.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width
//  MEM_WORDS   32  words implemented in data memory; word index >= MEM_WORDS is out of range
// PORTS
//  clk            in   1   clock; all state changes on posedge
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   pipeline presents an access
//  req_ready      out  1   1 only in IDLE; request accepted when req_valid&&req_ready at posedge
//  req_is_store   in   1   1=store, 0=load
//  req_funct3     in   3   RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   ADDR_WIDTH  byte address
//  req_wdata      in   32  store data (low byte/half used for SB/SH)
//  resp_valid     out  1   one-cycle pulse: access complete
//  resp_err       out  1   valid with resp_valid: misaligned/unsupported/out-of-range
//  load_data      out  32  extended load result; valid with resp_valid on a load
//  mem_r_enable   out  1   to data memory r_enable
//  mem_w_enable   out  1   to data memory w_enable
//  mem_address    out  ADDR_WIDTH  word-aligned address to memory, bits[1:0]=00
//  mem_wr_data    out  32  to data memory wr_data
//  mem_re_data    in   32  from data memory re_data (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, resp_err, load_data, mem_r_enable, mem_w_enable, mem_address and mem_wr_data are all 0.
//   rst during any state aborts the access: no memory write in the cycle after the reset edge, and no resp_valid.
//  On accept: latch addr, wdata, funct3 and is_store.
//   Error if any of:
//   - H/HU access with addr[0]=1
//   - W access with addr[1:0]!=0
//   - load funct3 in {011,110,111}
//   - store funct3 not in {000,001,010}
//   - addr[ADDR_WIDTH-1:2] >= MEM_WORDS
//  FSM states: IDLE, ACCESS, RMW_WR, RESP.
//   IDLE: req_ready=1; on accept -> RESP with resp_err=1 if error, else -> ACCESS. No memory access is made on error.
//   ACCESS, load: mem_r_enable=1.
//    - Byte lane = addr[1:0]; half lane = addr[1].
//    - B/H sign-extend; BU/HU zero-extend.
//    - Result registered into load_data at the end of ACCESS -> RESP.
//   ACCESS, SW: mem_w_enable=1, mem_wr_data=wdata -> RESP.
//   ACCESS, SB/SH: mem_r_enable=1; capture mem_re_data into the rmw register -> RMW_WR.
//   RMW_WR: mem_w_enable=1. mem_wr_data = rmw word with the target byte/half lane replaced by wdata[7:0]/[15:0]; other lanes unchanged -> RESP.
//   RESP: resp_valid=1 for exactly one cycle -> IDLE. load_data holds its value until the next load completes.
//  Latency (accept edge = cycle 0): load/SW resp_valid in cycle 2; SB/SH in cycle 3; error in cycle 1.
//   Back-to-back: the next request can be accepted the cycle after RESP.
//  Invariants:
//   - mem_r_enable and mem_w_enable are never both 1.
//   - Both are 0 in IDLE and RESP.
//   - mem_address = {latched_addr[ADDR_WIDTH-1:2],2'b00} whenever an enable is high, else 0.
//   - req_* inputs are ignored when req_ready=0.
// TESTING
//  1. mem[1]=0x8899AABB; LB addr 0x7 -> cycle 2 resp_valid, load_data=0xFFFFFF88; LBU addr 0x7 -> 0x00000088; LH addr 0x4 -> 0xFFFFAABB.
//  2. SB addr 0x5 wdata 0x123456CC on mem[1]=0x8899AABB -> r_enable cycle 1, w_enable cycle 2, mem[1]=0x8899CCBB, resp_valid cycle 3.
//  3. SW addr 0x8 wdata 0xDEADBEEF then LW addr 0x8 back-to-back -> load_data=0xDEADBEEF; r_enable and w_enable never both high.
//  4. LW addr 0x6, SH addr 0x3, LW addr 0x80 (MEM_WORDS=32) -> each: resp_valid+resp_err cycle 1, no enable ever asserted.
//  5. rst asserted during RMW_WR of an SH -> no mem write after the reset edge, outputs 0, req_ready=1 next cycle, no resp_valid.
//  6. req_valid held high through an SB -> exactly one access per accept; req_ready=0 during ACCESS/RMW_WR/RESP.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Bundles the signals around the MEM-stage load/store controller. Two groups
// are carried:
//   Pipeline side : req_valid/req_ready handshake, req_is_store, req_funct3,
//                   req_addr, req_wdata in; resp_valid, resp_err, load_data out.
//   Memory side   : mem_r_enable, mem_w_enable, mem_address, mem_wr_data out;
//                   mem_re_data in (combinational read from the data memory).
// The "slave" modport is the controller's view. The "master" modport is the
// view of whatever surrounds it: the pipeline plus the data memory.
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  resp_valid;
  logic                  resp_err;
  logic [31:0]           load_data;

  logic                  mem_r_enable;
  logic                  mem_w_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_wr_data;
  logic [31:0]           mem_re_data;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_re_data,
    input  req_ready, resp_valid, resp_err, load_data,
           mem_r_enable, mem_w_enable, mem_address, mem_wr_data
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_re_data,
    output req_ready, resp_valid, resp_err, load_data,
           mem_r_enable, mem_w_enable, mem_address, mem_wr_data
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// MEM-stage load/store initiator in front of a word-only data memory.
// Sub-word loads pick a byte/half lane and sign- or zero-extend it. Sub-word
// stores use a read-modify-write, because the memory can only write whole
// words. Misaligned, unsupported and out-of-range accesses are answered with
// resp_err and never reach the memory.
//
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, aborts any access in flight
//   bus  : lsu_mem_ctrl_if.slave
//          pipeline side: req_valid/req_ready, req_is_store, req_funct3,
//                         req_addr, req_wdata -> resp_valid, resp_err, load_data
//          memory side:   mem_r_enable, mem_w_enable, mem_address,
//                         mem_wr_data -> mem_re_data
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 32
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

  state_t                r_state;
  state_t                w_nextState;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_funct3;
  logic                  r_isStore;
  logic                  r_err;
  logic [31:0]           r_rmwWord;
  logic [31:0]           r_loadData;

  logic                  w_misaligned;
  logic                  w_unsupported;
  logic                  w_outOfRange;
  logic                  w_reqErr;

  logic [7:0]            w_loadByte;
  logic [15:0]           w_loadHalf;
  logic [31:0]           w_loadExt;
  logic [31:0]           w_mergedWord;

  logic                  w_reqReady;
  logic                  w_respValid;
  logic                  w_respErr;
  logic                  w_rdEn;
  logic                  w_wrEn;
  logic [31:0]           w_wrData;

  // Classify the request as presented. Only meaningful while IDLE, since that
  // is the only state in which it can be accepted.
  always_comb begin
    w_misaligned  = 1'b0;
    w_unsupported = 1'b0;
    w_outOfRange  = 1'b0;

    if ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0])
      w_misaligned = 1'b1;
    if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00)
      w_misaligned = 1'b1;

    if (bus.req_is_store)
      w_unsupported = !(bus.req_funct3 == F3_B || bus.req_funct3 == F3_H ||
                        bus.req_funct3 == F3_W);
    else
      w_unsupported = (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                       bus.req_funct3 == 3'b111);

    w_outOfRange = (bus.req_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT);

    w_reqErr = w_misaligned | w_unsupported | w_outOfRange;
  end

  // Load path: select the addressed lane of the word being read and extend it
  // according to the latched funct3.
  always_comb begin
    w_loadByte = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_loadByte = bus.mem_re_data[7:0];
      2'd1:    w_loadByte = bus.mem_re_data[15:8];
      2'd2:    w_loadByte = bus.mem_re_data[23:16];
      default: w_loadByte = bus.mem_re_data[31:24];
    endcase

    w_loadHalf = r_addr[1] ? bus.mem_re_data[31:16] : bus.mem_re_data[15:0];

    w_loadExt = bus.mem_re_data;
    case (r_funct3)
      F3_B:    w_loadExt = {{24{w_loadByte[7]}}, w_loadByte};
      F3_H:    w_loadExt = {{16{w_loadHalf[15]}}, w_loadHalf};
      F3_BU:   w_loadExt = {24'h000000, w_loadByte};
      F3_HU:   w_loadExt = {16'h0000, w_loadHalf};
      default: w_loadExt = bus.mem_re_data;
    endcase
  end

  // Store merge: the word captured during ACCESS with only the target lane
  // replaced by the low byte/half of the store data.
  always_comb begin
    w_mergedWord = r_rmwWord;
    if (r_funct3 == F3_B) begin
      case (r_addr[1:0])
        2'd0:    w_mergedWord[7:0]   = r_wdata[7:0];
        2'd1:    w_mergedWord[15:8]  = r_wdata[7:0];
        2'd2:    w_mergedWord[23:16] = r_wdata[7:0];
        default: w_mergedWord[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_mergedWord[31:16] = r_wdata[15:0];
    end else begin
      w_mergedWord[15:0] = r_wdata[15:0];
    end
  end

  // Next-state and output decode. Memory enables are only ever raised in
  // ACCESS or RMW_WR, and never both in the same state.
  always_comb begin
    w_nextState = r_state;
    w_reqReady  = 1'b0;
    w_respValid = 1'b0;
    w_respErr   = 1'b0;
    w_rdEn      = 1'b0;
    w_wrEn      = 1'b0;
    w_wrData    = 32'h0000_0000;

    case (r_state)
      IDLE: begin
        w_reqReady = 1'b1;
        if (bus.req_valid)
          w_nextState = w_reqErr ? RESP : ACCESS;
      end
      ACCESS: begin
        if (r_isStore && r_funct3 == F3_W) begin
          w_wrEn      = 1'b1;
          w_wrData    = r_wdata;
          w_nextState = RESP;
        end else begin
          w_rdEn      = 1'b1;
          w_nextState = r_isStore ? RMW_WR : RESP;
        end
      end
      RMW_WR: begin
        w_wrEn      = 1'b1;
        w_wrData    = w_mergedWord;
        w_nextState = RESP;
      end
      RESP: begin
        w_respValid = 1'b1;
        w_respErr   = r_err;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register. Reset drops straight back to IDLE, abandoning any access.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Datapath registers: request latch on accept, read-back word for the RMW,
  // and the load result, which holds until the next load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= 32'h0000_0000;
      r_funct3   <= 3'b000;
      r_isStore  <= 1'b0;
      r_err      <= 1'b0;
      r_rmwWord  <= 32'h0000_0000;
      r_loadData <= 32'h0000_0000;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_addr    <= bus.req_addr;
        r_wdata   <= bus.req_wdata;
        r_funct3  <= bus.req_funct3;
        r_isStore <= bus.req_is_store;
        r_err     <= w_reqErr;
      end
      if (r_state == ACCESS && !r_isStore)
        r_loadData <= w_loadExt;
      if (r_state == ACCESS && r_isStore)
        r_rmwWord <= bus.mem_re_data;
    end
  end

  assign bus.req_ready    = w_reqReady;
  assign bus.resp_valid   = w_respValid;
  assign bus.resp_err     = w_respErr;
  assign bus.load_data    = r_loadData;
  assign bus.mem_r_enable = w_rdEn;
  assign bus.mem_w_enable = w_wrEn;
  assign bus.mem_wr_data  = w_wrData;
  assign bus.mem_address  = (w_rdEn || w_wrEn) ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;

endmodule
